// File: rtl/decode_ctrl_if.sv
// ---------------------------------------------------------------------------
// decode_ctrl_if -- IF->ID handoff bundle for the decode control block.
//   IF side   : instr_F, pc_F, valid_F            (fetched instruction)
//   hazard    : stall_D, flush_D                  (hold / bubble the IF/ID reg)
//   status    : clr_err                           (clear illegal-op status)
//   D side    : instr_D, pc_D, valid_D, immD, imm_used_D, illegal_D
//   error     : err_valid, err_pc, err_cnt
// master = the pipeline driving IF/hazard inputs; slave = decode_ctrl.
// ---------------------------------------------------------------------------
interface decode_ctrl_if;
   logic [31:0] instr_F;
   logic [31:0] pc_F;
   logic        valid_F;
   logic        stall_D;
   logic        flush_D;
   logic        clr_err;
   logic [31:0] instr_D;
   logic [31:0] pc_D;
   logic        valid_D;
   logic [2:0]  immD;
   logic        imm_used_D;
   logic        illegal_D;
   logic        err_valid;
   logic [31:0] err_pc;
   logic [7:0]  err_cnt;

   modport master (
      output instr_F, pc_F, valid_F, stall_D, flush_D, clr_err,
      input  instr_D, pc_D, valid_D, immD, imm_used_D, illegal_D,
             err_valid, err_pc, err_cnt
   );

   modport slave (
      input  instr_F, pc_F, valid_F, stall_D, flush_D, clr_err,
      output instr_D, pc_D, valid_D, immD, imm_used_D, illegal_D,
             err_valid, err_pc, err_cnt
   );
endinterface

// File: rtl/decode_ctrl.sv
// ---------------------------------------------------------------------------
// decode_ctrl -- IF/ID pipeline register with immediate-type pre-decode and
// sticky illegal-opcode status.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : decode_ctrl_if.slave (IF inputs, hazard controls, D outputs, error)
// Immediate select (immD): 000 I, 001 S, 010 B, 011 U, 100 J, 101 shamt.
// Update priority per edge: rst > flush_D > stall_D > load.
// ---------------------------------------------------------------------------
module decode_ctrl (
   input  logic          clk,
   input  logic          rst,
   decode_ctrl_if.slave  bus
);
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [2:0]  IMM_I  = 3'b000;
   localparam logic [2:0]  IMM_S  = 3'b001;
   localparam logic [2:0]  IMM_B  = 3'b010;
   localparam logic [2:0]  IMM_U  = 3'b011;
   localparam logic [2:0]  IMM_J  = 3'b100;
   localparam logic [2:0]  IMM_SH = 3'b101;

   logic [31:0] r_instr;
   logic [31:0] r_pc;
   logic        r_valid;
   logic [2:0]  r_imm;
   logic        r_imm_used;
   logic        r_illegal;
   logic        r_err_valid;
   logic [31:0] r_err_pc;
   logic [7:0]  r_err_cnt;

   logic [2:0]  w_imm;
   logic        w_imm_used;
   logic        w_illegal;
   logic        w_load;
   logic        w_ill_evt;
   logic [2:0]  w_funct3;

   assign w_funct3 = bus.instr_F[14:12];

   // Pre-decode straight off instr_F so the fields land in D with the instr.
   always_comb begin
      w_imm      = IMM_I;
      w_imm_used = 1'b1;
      w_illegal  = 1'b0;
      case (bus.instr_F[6:0])
         7'b0000011,
         7'b1100111,
         7'b1110011: w_imm = IMM_I;
         7'b0010011: begin
            // slli/srli/srai carry a 5-bit shamt, not a 12-bit immediate
            if (w_funct3 == 3'b001 || w_funct3 == 3'b101) w_imm = IMM_SH;
         end
         7'b0100011: w_imm = IMM_S;
         7'b1100011: w_imm = IMM_B;
         7'b0110111,
         7'b0010111: w_imm = IMM_U;
         7'b1101111: w_imm = IMM_J;
         7'b0110011: w_imm_used = 1'b0;
         default: begin
            w_imm_used = 1'b0;
            w_illegal  = 1'b1;
         end
      endcase
   end

   assign w_load    = !bus.flush_D && !bus.stall_D;
   // Only a fresh, real instruction entering D counts; held ones do not.
   assign w_ill_evt = w_load && bus.valid_F && w_illegal;

   // IF/ID register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_instr    <= NOP;
         r_pc       <= '0;
         r_valid    <= 1'b0;
         r_imm      <= IMM_I;
         r_imm_used <= 1'b0;
         r_illegal  <= 1'b0;
      end else if (bus.flush_D) begin
         // bubble; pc_D deliberately keeps its value
         r_instr    <= NOP;
         r_valid    <= 1'b0;
         r_imm      <= IMM_I;
         r_imm_used <= 1'b0;
         r_illegal  <= 1'b0;
      end else if (!bus.stall_D) begin
         r_pc <= bus.pc_F;
         if (bus.valid_F) begin
            r_instr    <= bus.instr_F;
            r_valid    <= 1'b1;
            r_imm      <= w_imm;
            r_imm_used <= w_imm_used;
            r_illegal  <= w_illegal;
         end else begin
            r_instr    <= NOP;
            r_valid    <= 1'b0;
            r_imm      <= IMM_I;
            r_imm_used <= 1'b0;
            r_illegal  <= 1'b0;
         end
      end
   end

   // Error status; a new illegal event beats a coincident clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err_valid <= 1'b0;
         r_err_pc    <= '0;
         r_err_cnt   <= '0;
      end else if (w_ill_evt) begin
         if (bus.clr_err || !r_err_valid) begin
            r_err_valid <= 1'b1;
            r_err_pc    <= bus.pc_F;
         end
         if (bus.clr_err)               r_err_cnt <= 8'd1;
         else if (r_err_cnt != 8'hFF)   r_err_cnt <= r_err_cnt + 8'd1;
      end else if (bus.clr_err) begin
         r_err_valid <= 1'b0;
         r_err_pc    <= '0;
         r_err_cnt   <= '0;
      end
   end

   assign bus.instr_D    = r_instr;
   assign bus.pc_D       = r_pc;
   assign bus.valid_D    = r_valid;
   assign bus.immD       = r_imm;
   assign bus.imm_used_D = r_imm_used;
   assign bus.illegal_D  = r_illegal;
   assign bus.err_valid  = r_err_valid;
   assign bus.err_pc     = r_err_pc;
   assign bus.err_cnt    = r_err_cnt;
endmodule

// File: doc/decode_ctrl.md
DECODE_CTRL -- requirements
Module: decode_ctrl

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  synchronous, active-high reset; sampled on rising edge of clk only.
REQ-003 instr_F  input  32  fetched instruction from IF stage.
REQ-004 pc_F  input  32  PC of instr_F.
REQ-005 valid_F  input  1  instr_F/pc_F carry a real instruction.
REQ-006 stall_D  input  1  hold the IF/ID register contents (from hazard unit).
REQ-007 flush_D  input  1  replace the IF/ID register contents with a bubble (branch/jump redirect).
REQ-008 clr_err  input  1  clear illegal-instruction status (err_valid, err_pc, err_cnt).
REQ-009 instr_D  output  32  registered instruction; bits [31:7] drive the sign extender.
REQ-010 pc_D  output  32  registered PC.
REQ-011 valid_D  output  1  instr_D is a real instruction.
REQ-012 immD  output  3  registered immediate-type select for the sign extender.
REQ-013 imm_used_D  output  1  instr_D consumes an immediate.
REQ-014 illegal_D  output  1  instr_D has an unsupported opcode.
REQ-015 err_valid  output  1  sticky: at least one illegal instruction has entered decode since the last clear.
REQ-016 err_pc  output  32  PC of the first illegal instruction since the last clear.
REQ-017 err_cnt  output  8  saturating count of illegal instructions that entered decode.

Function
REQ-018 immD encoding SHALL be: 000 I; 001 S; 010 B; 011 U; 100 J; 101 shift-amount (zero-extended instr[24:20]).
REQ-019 Opcode map (instr_F[6:0]) SHALL be:
- 0000011 load, 1100111 JALR, 1110011 SYSTEM -> I.
- 0010011 OP-IMM -> I, except funct3 001/101 -> 101.
- 0100011 -> S.
- 1100011 -> B.
- 0110111, 0010111 -> U.
- 1101111 -> J.
- 0110011 R-type -> immD 000, imm_used 0.
- Any other opcode -> immD 000, imm_used 0, illegal 1.
REQ-020 immD, imm_used_D and illegal_D SHALL be computed from instr_F and registered together with instr_D (zero added latency in D; one clk from IF to D).
REQ-021 Per rising edge, the update priority SHALL be rst > flush_D > stall_D > load.
REQ-022 Load (no rst/flush/stall): instr_D<=instr_F, pc_D<=pc_F, valid_D<=valid_F, with decoded fields from REQ-019.
REQ-023 Load with valid_F=0 SHALL produce a bubble.
  - Bubble: instr_D=32'h00000013, valid_D=0, immD=000, imm_used_D=0, illegal_D=0, pc_D<=pc_F.
REQ-024 flush_D=1 SHALL load a bubble regardless of stall_D (flush wins over stall); pc_D SHALL keep its value.
REQ-025 stall_D=1 with flush_D=0 SHALL hold every D-stage output unchanged.
REQ-026 An illegal entry event SHALL occur only on a load edge where valid_F=1 and the opcode is illegal; held (stalled) instructions SHALL NOT recount.
REQ-027 On an illegal entry event:
  - err_cnt SHALL increment, saturating at 8'hFF.
  - If err_valid=0, err_pc<=pc_F and err_valid<=1; otherwise err_pc SHALL hold.
REQ-028 clr_err=1 SHALL clear err_valid, err_pc and err_cnt to 0.
  - If clr_err and an illegal entry event coincide, the new event SHALL win: err_valid=1, err_pc=pc_F, err_cnt=1.
REQ-029 Error state SHALL be unaffected by stall_D or flush_D except through REQ-026.

Reset
REQ-030 On rst, the outputs SHALL take these values:
  - instr_D=32'h00000013, pc_D=0, valid_D=0.
  - immD=000, imm_used_D=0, illegal_D=0.
  - err_valid=0, err_pc=0, err_cnt=0.
REQ-031 rst asserted mid-stall or mid-flush SHALL override both, and the first load after rst deasserts SHALL behave per REQ-022.

Verification
REQ-032 instr_F=32'h00A00093 (addi), valid_F=1, pc_F=0x100 -> next edge: valid_D=1, immD=000, imm_used_D=1, pc_D=0x100.
REQ-033 Sequence of sw, beq, lui, jal, slli -> immD 001, 010, 011, 100, 101 on consecutive cycles; add (0x00208133) -> imm_used_D=0.
REQ-034 stall_D=1 for 3 cycles with a changing instr_F -> instr_D/immD constant; stall_D and flush_D both 1 -> bubble (0x00000013, valid_D=0).
REQ-035 Opcode 0x7F at pc 0x200, then 0x7F at pc 0x204 -> illegal_D=1 each, err_pc=0x200, err_cnt=2; same instruction held by stall -> err_cnt stays 2.
REQ-036 Inject 300 illegal instructions -> err_cnt=0xFF; clr_err coincident with an illegal at pc 0x300 -> err_cnt=1, err_pc=0x300.
REQ-037 rst asserted during a stall with err_cnt=5 -> all outputs at REQ-030 values on the next edge.
